// File: rtl/clock_step_ctrl.sv
// -----------------------------------------------------------------------------
// clock_step_ctrl
// Consumer end of the board clock divider. Samples the divided processor clock
// (divclock) in the CLOCK_50 domain and turns each rising edge into a single
// CLOCK_50-cycle enable pulse (cpu_en). Adds halt, free-run and single-step
// modes. Single-step uses a debounced, active-low push-button (Key).
//
// Optional feature macro: CLOCK_STEP_MISS_DETECT_EN
//   When defined, adds a sticky miss_flag output, and LEDR blinks at the
//   divclock rate while miss_flag is set.
//
// Ports:
//   CLOCK_50     in   system clock
//   reset        in   synchronous, active-high reset
//   divclock     in   divided clock, asynchronous to CLOCK_50
//   Key          in   step push-button, active-low, raw/bouncy
//   run_mode     in   1 = free-run, 0 = single-step (asynchronous)
//   halt         in   1 = stop the processor (asynchronous)
//   cpu_en       out  registered one-cycle enable for the processor
//   LEDR[3:0]    out  one-hot state: [0] HALT [1] RUN [2] STEP_IDLE [3] STEP_ARMED
//   cycle_count  out  number of cpu_en pulses issued (wraps)
//   miss_flag    out  (CLOCK_STEP_MISS_DETECT_EN only) sticky overrun/ignored-press
// -----------------------------------------------------------------------------
module clock_step_ctrl #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 16
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             divclock,
    input  logic             Key,
    input  logic             run_mode,
    input  logic             halt,
    output logic             cpu_en,
    output logic [3:0]       LEDR,
`ifdef CLOCK_STEP_MISS_DETECT_EN
    output logic             miss_flag,
`endif
    output logic [CNT_W-1:0] cycle_count
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    // State codes are the LED pattern, so the state register drives LEDR directly.
    typedef enum logic [3:0] {
        S_HALT       = 4'b0001,
        S_RUN        = 4'b0010,
        S_STEP_IDLE  = 4'b0100,
        S_STEP_ARMED = 4'b1000
    } state_t;

    state_t state;

    logic [SYNC_STAGES-1:0] div_sync, key_sync, run_sync, halt_sync;
    logic div_s, key_s, run_s, halt_s;
    logic div_d;
    logic div_rise;
    logic key_db, key_db_q;
    logic press;
    logic [DB_W-1:0] db_cnt;

    // Input synchronizers; the Key chain resets to the released level.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            div_sync  <= '0;
            key_sync  <= '1;
            run_sync  <= '0;
            halt_sync <= '0;
        end else begin
            div_sync  <= {div_sync[SYNC_STAGES-2:0], divclock};
            key_sync  <= {key_sync[SYNC_STAGES-2:0], Key};
            run_sync  <= {run_sync[SYNC_STAGES-2:0], run_mode};
            halt_sync <= {halt_sync[SYNC_STAGES-2:0], halt};
        end
    end

    assign div_s  = div_sync[SYNC_STAGES-1];
    assign key_s  = key_sync[SYNC_STAGES-1];
    assign run_s  = run_sync[SYNC_STAGES-1];
    assign halt_s = halt_sync[SYNC_STAGES-1];

    always_ff @(posedge CLOCK_50) begin
        if (reset) div_d <= 1'b0;
        else       div_d <= div_s;
    end

    assign div_rise = div_s & ~div_d;

    // Debounce: a new Key level is accepted only after DEBOUNCE_CYCLES
    // consecutive cycles of disagreement with the current debounced level.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            key_db   <= 1'b1;
            key_db_q <= 1'b1;
            db_cnt   <= '0;
        end else begin
            key_db_q <= key_db;
            if (key_s != key_db) begin
                if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    key_db <= key_s;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // Press is the falling edge of the debounced level; release is ignored.
    assign press = key_db_q & ~key_db;

    // Mode FSM. halt always wins; leaving STEP_ARMED for any reason drops the step.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state  <= S_HALT;
            cpu_en <= 1'b0;
        end else begin
            cpu_en <= 1'b0;
            case (state)
                S_HALT: begin
                    if (!halt_s) state <= run_s ? S_RUN : S_STEP_IDLE;
                end
                S_RUN: begin
                    if (halt_s)      state  <= S_HALT;
                    else if (!run_s) state  <= S_STEP_IDLE;
                    else             cpu_en <= div_rise;
                end
                S_STEP_IDLE: begin
                    // A press coinciding with div_rise only arms; it fires on
                    // the following divclock edge so step timing matches run.
                    if (halt_s)     state <= S_HALT;
                    else if (run_s) state <= S_RUN;
                    else if (press) state <= S_STEP_ARMED;
                end
                S_STEP_ARMED: begin
                    if (halt_s)     state <= S_HALT;
                    else if (run_s) state <= S_RUN;
                    else if (div_rise) begin
                        cpu_en <= 1'b1;
                        state  <= S_STEP_IDLE;
                    end
                end
                default: state <= S_HALT;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset)       cycle_count <= '0;
        else if (cpu_en) cycle_count <= cycle_count + CNT_W'(1);
    end

`ifdef CLOCK_STEP_MISS_DETECT_EN
    // Sticky: divclock edge while the previous enable is still out, or a
    // press swallowed because a step is already armed.
    always_ff @(posedge CLOCK_50) begin
        if (reset)
            miss_flag <= 1'b0;
        else if ((div_rise && cpu_en) || (state == S_STEP_ARMED && press))
            miss_flag <= 1'b1;
    end

    assign LEDR = miss_flag ? {4{div_s}} : state;
`else
    assign LEDR = state;
`endif

endmodule

// File: tb/tb_clock_step_ctrl.sv
module tb_clock_step_ctrl;

    localparam int S  = 2;
    localparam int D  = 8;
    localparam int CW = 4;

    logic          CLOCK_50;
    logic          reset;
    logic          divclock;
    logic          Key;
    logic          run_mode;
    logic          halt;
    logic          cpu_en;
    logic [3:0]    LEDR;
    logic [CW-1:0] cycle_count;
`ifdef CLOCK_STEP_MISS_DETECT_EN
    logic          miss_flag;
`endif

    clock_step_ctrl #(
        .SYNC_STAGES    (S),
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (CW)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .divclock   (divclock),
        .Key        (Key),
        .run_mode   (run_mode),
        .halt       (halt),
        .cpu_en     (cpu_en),
        .LEDR       (LEDR),
`ifdef CLOCK_STEP_MISS_DETECT_EN
        .miss_flag  (miss_flag),
`endif
        .cycle_count(cycle_count)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    int errors = 0;
    int checks = 0;

    // Input history, indexed by the edge number that sampled it.
    bit h_rst  [0:32767];
    bit h_div  [0:32767];
    bit h_key  [0:32767];
    bit h_run  [0:32767];
    bit h_halt [0:32767];
    int edge_n = 0;
    int last_rst = 0;

    // Reference model: mode 0 halted, 1 running, 2 waiting for a step, 3 step armed.
    int m_mode = 0;
    bit m_en = 0;
    int m_cnt = 0;
    bit m_db = 1;
    int m_disagree = 0;
    bit m_press = 0;

    // Stimulus bookkeeping
    bit div_auto = 0;
    bit div_rand = 0;
    int div_half = 32;
    int div_ctr = 0;
    bit prev_div_in = 0;
    int last_in_rise = 0;
    int pulses = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // An input reaches the logic SYNC_STAGES edges after it is sampled;
    // anything sampled at or before the last reset is replaced by the reset level.
    function automatic bit seen(input bit v, input int idx, input bit rv);
        return (idx > last_rst) ? v : rv;
    endfunction

    function automatic void model_edge(input int n);
        bit s_div, s_div_prev, s_key, s_run, s_halt, rise, press;
        if (h_rst[n]) begin
            m_mode = 0; m_en = 0; m_cnt = 0; m_db = 1; m_disagree = 0; m_press = 0;
            last_rst = n;
            return;
        end
        s_div      = seen(h_div[n-S], n-S, 1'b0);
        s_div_prev = seen(h_div[n-S-1], n-S-1, 1'b0);
        s_key      = seen(h_key[n-S], n-S, 1'b1);
        s_run      = seen(h_run[n-S], n-S, 1'b0);
        s_halt     = seen(h_halt[n-S], n-S, 1'b0);
        rise  = s_div && !s_div_prev;
        press = m_press;
        m_press = 0;
        if (m_en) m_cnt = (m_cnt + 1) % (1 << CW);
        m_en = 0;
        if (s_halt) m_mode = 0;
        else begin
            case (m_mode)
                0: m_mode = s_run ? 1 : 2;
                1: if (!s_run) m_mode = 2; else m_en = rise;
                2: if (s_run) m_mode = 1; else if (press) m_mode = 3;
                default: if (s_run) m_mode = 1; else if (rise) begin m_en = 1; m_mode = 2; end
            endcase
        end
        if (s_key != m_db) begin
            m_disagree++;
            if (m_disagree == D) begin
                m_db = s_key;
                m_disagree = 0;
                m_press = (s_key == 1'b0);
            end
        end else m_disagree = 0;
    endfunction

    task automatic tick();
        int e;
        if (div_auto) begin
            div_ctr++;
            if (div_ctr >= div_half) begin
                div_ctr = 0;
                divclock = ~divclock;
                if (div_rand) div_half = $urandom_range(3, 20);
            end
        end
        e = edge_n + 1;
        h_rst[e] = reset; h_div[e] = divclock; h_key[e] = Key;
        h_run[e] = run_mode; h_halt[e] = halt;
        if (divclock && !prev_div_in) last_in_rise = e;
        prev_div_in = divclock;
        @(posedge CLOCK_50);
        edge_n = e;
        model_edge(e);
        @(negedge CLOCK_50);
        chk("cpu_en", int'(cpu_en), int'(m_en));
        chk("LEDR", int'(LEDR), 1 << m_mode);
        chk("cycle_count", int'(cycle_count), m_cnt);
        if (cpu_en === 1'b1) begin
            pulses++;
            chk("en_latency", edge_n - last_in_rise, S);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    int base_cnt;
    int base_pulses;
    int key_hold;

    initial begin
        reset = 1'b1; halt = 1'b1; run_mode = 1'b0; Key = 1'b1; divclock = 1'b0;

        // 1: reset, then halted while divclock runs
        ticks(3);
        reset = 1'b0;
        div_auto = 1;
        ticks(200);
        chk("halt_pulses", pulses, 0);
        chk("halt_led", int'(LEDR), 1);
        chk("halt_count", int'(cycle_count), 0);

        // 2: free-run, one enable per divclock rise
        halt = 1'b0; run_mode = 1'b1;
        ticks(4);
        chk("run_led", int'(LEDR), 2);
        for (int i = 0; i < 2000 && pulses < 10; i++) tick();
        tick();
        chk("run_pulses", pulses, 10);
        chk("run_count", int'(cycle_count), 10);

        // 3: single-step with a bouncy button
        div_auto = 0; divclock = 1'b0; div_ctr = 0;
        run_mode = 1'b0;
        ticks(6);
        chk("idle_led", int'(LEDR), 4);
        base_cnt = int'(cycle_count); base_pulses = pulses;
        for (int i = 0; i < 6; i++) begin
            Key = 1'b0; ticks(3);
            Key = 1'b1; ticks(3);
        end
        chk("bounce_led", int'(LEDR), 4);
        Key = 1'b0; ticks(20);
        chk("armed_led", int'(LEDR), 8);
        Key = 1'b1; ticks(12);
        div_auto = 1;
        ticks(150);
        chk("step_pulses", pulses - base_pulses, 1);
        chk("step_led", int'(LEDR), 4);
        chk("step_count", int'(cycle_count), (base_cnt + 1) % (1 << CW));

        // 4: halt while armed drops the step
        div_auto = 0; divclock = 1'b0; div_ctr = 0;
        ticks(6);
        Key = 1'b0; ticks(20);
        chk("armed2_led", int'(LEDR), 8);
        Key = 1'b1;
        halt = 1'b1;
        ticks(4);
        base_cnt = int'(cycle_count); base_pulses = pulses;
        div_auto = 1;
        ticks(150);
        chk("drop_pulses", pulses - base_pulses, 0);
        chk("drop_led", int'(LEDR), 1);
        chk("drop_count", int'(cycle_count), base_cnt);

        // 5: counter wrap after 17 enables
        div_auto = 0; divclock = 1'b0; div_ctr = 0;
        reset = 1'b1; halt = 1'b0; run_mode = 1'b1;
        ticks(2);
        reset = 1'b0;
        pulses = 0;
        div_auto = 1;
        for (int i = 0; i < 3000 && pulses < 17; i++) tick();
        tick();
        chk("wrap_pulses", pulses, 17);
        chk("wrap_count", int'(cycle_count), 1);

        // 6: reset on the cycle div_rise is high
        div_auto = 0; divclock = 1'b0; div_ctr = 0;
        ticks(6);
        base_pulses = pulses;
        divclock = 1'b1;
        ticks(2);
        reset = 1'b1;
        tick();
        chk("rst_en", int'(cpu_en), 0);
        chk("rst_led", int'(LEDR), 1);
        chk("rst_count", int'(cycle_count), 0);
        divclock = 1'b0;
        ticks(3);
        chk("rst_no_pulse", pulses - base_pulses, 0);

        // Randomized mode/button/divclock activity against the model
        reset = 1'b0; halt = 1'b0; run_mode = 1'b1;
        div_auto = 1; div_rand = 1; key_hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) halt = ~halt;
            if ($urandom_range(0, 99) == 0) run_mode = ~run_mode;
            if (key_hold == 0) begin
                Key = 1'($urandom_range(0, 1));
                key_hold = $urandom_range(1, 20);
            end else key_hold--;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
